// File: rtl/fifo_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bank_pkg
// Description : Shared definitions for the multi-lane FIFO bank. Holds the
//               default geometry and the width helpers that turn FIFO_SIZE
//               and the lane geometry into pointer, count and bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_bank_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_SIZE  = 4608;
  localparam int DEF_NUM_LANES  = 8;

  // Pointer width: enough bits to address entries 0..size-1.
  function automatic int ptr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Count width: enough bits to hold 0..size inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

  // Width of a packed multi-lane bus; lane k sits at [k*width +: width].
  function automatic int bus_width(input int lanes, input int width);
    return lanes * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_lane.sv
`default_nettype none
// ============================================================================
// Module      : fifo_lane
// Description : Single-lane storage of DATA_WIDTH x FIFO_SIZE words plus a
//               registered read port. All addressing and accept decisions
//               come from the parent bank; this block only stores and reads.
// Ports       : clk, reset      - clock, async active-high reset
//               wr_en/wr_addr/wr_data - accepted write into storage
//               rd_en/rd_addr   - accepted read; rd_data updates next edge
//               rd_data         - registered read word, 0 when no read
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_lane
  import fifo_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_SIZE  = DEF_FIFO_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ptr_width(FIFO_SIZE)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ptr_width(FIFO_SIZE)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register drives zero in any cycle without an accepted read.
  always_comb begin
    data_out_d = '0;
    if (rd_en) begin
      data_out_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign rd_data = data_out_q;

endmodule
`default_nettype wire

// File: rtl/fifo_bank.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bank
// Description : NUM_LANES parallel FIFOs sharing one read/write pointer pair,
//               one occupancy count and one set of status flags. Supports
//               peek reads, overwrite-in-place writes, read rewind (rd_clr)
//               and full flush (wr_clr).
// Ports       : clk, reset              - clock, async active-high reset
//               rd_clr / wr_clr         - rewind read side / flush write side
//               rd_en, rd_inc           - read request, advance after read
//               wr_en, wr_inc           - write request, advance after write
//               data_in / data_out      - packed lane buses
//               data_valid              - data_out holds an accepted read
//               count, full, empty      - occupancy status
//               overflow, underflow     - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_bank
  import fifo_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
  parameter int NUM_LANES  = DEF_NUM_LANES
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      rd_clr,
  input  logic                                      wr_clr,
  input  logic                                      rd_en,
  input  logic                                      wr_en,
  input  logic                                      rd_inc,
  input  logic                                      wr_inc,
  input  logic [bus_width(NUM_LANES,DATA_WIDTH)-1:0] data_in,
  output logic [bus_width(NUM_LANES,DATA_WIDTH)-1:0] data_out,
  output logic                                      data_valid,
  output logic [cnt_width(FIFO_SIZE)-1:0]           count,
  output logic                                      full,
  output logic                                      empty,
  output logic                                      overflow,
  output logic                                      underflow
);

  localparam int PTR_W = ptr_width(FIFO_SIZE);
  localparam int CNT_W = cnt_width(FIFO_SIZE);

  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(FIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FIFO_SIZE);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             wrap_d, wrap_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             data_valid_d, data_valid_q;

  logic w_full, w_empty;
  logic w_wr_acc, w_rd_acc;
  logic w_wr_step, w_rd_step;

  // full/empty come from the registered count, so they reflect the state
  // at the start of the cycle when deciding acceptance.
  assign w_full    = (count_q == c_cnt_full);
  assign w_empty   = (count_q == '0);
  assign w_wr_acc  = wr_en & ~wr_clr & ~w_full;
  assign w_rd_acc  = rd_en & ~rd_clr & ~w_empty;
  assign w_wr_step = w_wr_acc & wr_inc;
  assign w_rd_step = w_rd_acc & rd_inc;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wrap_d       = wrap_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    data_valid_d = w_rd_acc;

    // Write pointer and wrap flag; the wrap flag records that every entry
    // has been written at least once since the last flush.
    if (wr_clr) begin
      wr_ptr_d = '0;
      wrap_d   = 1'b0;
    end else if (w_wr_step) begin
      if (wr_ptr_q == c_ptr_last) begin
        wr_ptr_d = '0;
        wrap_d   = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    if (rd_clr) begin
      rd_ptr_d = '0;
    end else if (w_rd_step) begin
      rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    // Rewind restores occupancy to everything written since the flush,
    // using the post-write pointer so a same-cycle write is included.
    if (wr_clr) begin
      count_d = '0;
    end else if (rd_clr) begin
      count_d = wrap_d ? c_cnt_full : CNT_W'(wr_ptr_d);
    end else begin
      case ({w_wr_step, w_rd_step})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (wr_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q  | (wr_en & w_full);
      underflow_d = underflow_q | (rd_en & ~rd_clr & w_empty);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wrap_q       <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wrap_q       <= wrap_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      data_valid_q <= data_valid_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    fifo_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_SIZE  (FIFO_SIZE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (w_rd_acc),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign data_valid = data_valid_q;
  assign count      = count_q;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_bank
// Description : Directed self-checking bench for fifo_bank with 2 lanes of
//               8 bits and 6 entries per lane.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_bank;

  localparam int DW = 8;
  localparam int FS = 6;
  localparam int NL = 2;

  logic        clk;
  logic        reset;
  logic        rd_clr, wr_clr, rd_en, wr_en, rd_inc, wr_inc;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [2:0]  count;
  logic        full, empty, overflow, underflow;

  int n_vec  = 0;
  int n_miss = 0;

  fifo_bank #(
    .DATA_WIDTH (DW),
    .FIFO_SIZE  (FS),
    .NUM_LANES  (NL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_clr     (rd_clr),
    .wr_clr     (wr_clr),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .rd_inc     (rd_inc),
    .wr_inc     (wr_inc),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic op(input logic we, input logic wi, input int d,
                    input logic re, input logic ri, input logic rc, input logic wc);
    wr_en = we; wr_inc = wi; data_in = 16'(d);
    rd_en = re; rd_inc = ri; rd_clr = rc; wr_clr = wc;
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_inc = 1'b0; data_in = '0;
    rd_en = 1'b0; rd_inc = 1'b0; rd_clr = 1'b0; wr_clr = 1'b0;
  endtask

  task automatic wr(input int d);
    op(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    op(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    op(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".count"},     32'(count),      0);
    chk({tag, ".empty"},     32'(empty),      1);
    chk({tag, ".full"},      32'(full),       0);
    chk({tag, ".valid"},     32'(data_valid), 0);
    chk({tag, ".dout"},      32'(data_out),   0);
    chk({tag, ".overflow"},  32'(overflow),   0);
    chk({tag, ".underflow"}, 32'(underflow),  0);
  endtask

  initial begin
    reset = 1'b1;
    rd_clr = 1'b0; wr_clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_inc = 1'b0; wr_inc = 1'b0; data_in = '0;
    #12;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, overflow on the 7th write, drain in order.
    for (int i = 1; i <= 6; i++) wr(i * 257);
    chk("fill.full",  32'(full),  1);
    chk("fill.count", 32'(count), 6);
    wr(16'h0707);
    chk("ovf.flag",  32'(overflow), 1);
    chk("ovf.count", 32'(count),    6);
    for (int i = 1; i <= 6; i++) begin
      rd();
      chk($sformatf("drain%0d.dout", i),  32'(data_out),   i * 257);
      chk($sformatf("drain%0d.valid", i), 32'(data_valid), 1);
    end
    chk("drain.empty", 32'(empty), 1);
    idle();
    chk("idle.dout",  32'(data_out),   0);
    chk("idle.valid", 32'(data_valid), 0);

    // Write 4, read 4, write 5 so the write pointer wraps around.
    flush();
    chk("flush.overflow", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) wr(16'h5000 + i);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk($sformatf("wrapA%0d", i), 32'(data_out), 16'h5000 + i);
    end
    for (int i = 0; i < 5; i++) wr(16'h6000 + i);
    chk("wrap.count", 32'(count), 5);
    for (int i = 0; i < 5; i++) begin
      rd();
      chk($sformatf("wrapB%0d", i), 32'(data_out), 16'h6000 + i);
    end
    chk("wrap.empty", 32'(empty), 1);

    // Peek: rd_inc=0 returns the same entry without consuming it.
    flush();
    wr(16'hAAAA);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("peek%0d.dout", i),  32'(data_out),   16'hAAAA);
      chk($sformatf("peek%0d.valid", i), 32'(data_valid), 1);
      chk($sformatf("peek%0d.count", i), 32'(count),      1);
    end

    // Rewind replays everything written since the flush.
    flush();
    for (int i = 0; i < 3; i++) wr(16'h0C01 + i);
    for (int i = 0; i < 3; i++) rd();
    chk("rew.empty", 32'(empty), 1);
    op(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rew.count", 32'(count),      3);
    chk("rew.valid", 32'(data_valid), 0);
    chk("rew.dout",  32'(data_out),   0);
    for (int i = 0; i < 3; i++) begin
      rd();
      chk($sformatf("replay%0d", i), 32'(data_out), 16'h0C01 + i);
      idle();
      chk($sformatf("replay%0d.idle", i), 32'(data_out), 0);
    end

    // Underflow, cleared by wr_clr; simultaneous read/write while full.
    flush();
    rd();
    chk("udf.valid", 32'(data_valid), 0);
    chk("udf.flag",  32'(underflow),  1);
    op(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("udf.clear", 32'(underflow), 0);
    for (int i = 1; i <= 6; i++) wr(16'h2100 + i);
    op(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rw.valid",    32'(data_valid), 1);
    chk("rw.dout",     32'(data_out),   16'h2101);
    chk("rw.overflow", 32'(overflow),   1);
    chk("rw.count",    32'(count),      5);
    for (int i = 2; i <= 6; i++) begin
      rd();
      chk($sformatf("rw.rest%0d", i), 32'(data_out), 16'h2100 + i);
    end
    chk("rw.empty", 32'(empty), 1);

    // Overwrite in place: wr_inc=0 stores but does not advance or count.
    flush();
    op(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovw.count", 32'(count), 0);
    wr(16'h5678);
    chk("ovw.count1", 32'(count), 1);
    rd();
    chk("ovw.dout", 32'(data_out), 16'h5678);

    // Asynchronous reset in the middle of a burst.
    flush();
    rd();
    wr(16'h3131); wr(16'h3232); wr(16'h3333);
    rd_en = 1'b1; rd_inc = 1'b1;
    @(posedge clk);
    #1;
    chk("async.pre", 32'(data_out), 16'h3131);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("async");
    rd_en = 1'b0; rd_inc = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    wr(16'h4444);
    chk("post.count", 32'(count), 1);
    rd();
    chk("post.dout", 32'(data_out), 16'h4444);
    chk("post.empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_bank.md
FIFO_BANK -- requirements
Module: fifo_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 16, lane word width in bits.
REQ-002 Parameter FIFO_SIZE, default 4608, entries per lane; any value >= 2, not restricted to powers of two.
REQ-003 Parameter NUM_LANES, default 8, lanes sharing one pointer pair.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd_clr  input  1  rewind read side to entry 0.
REQ-007 wr_clr  input  1  flush: clear write side, occupancy and error flags.
REQ-008 rd_en / wr_en  input  1 each  read / write request.
REQ-009 rd_inc / wr_inc  input  1 each  1 = advance pointer after access; 0 = peek (read) or overwrite-in-place (write).
REQ-010 data_in  input  NUM_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 data_out  output  NUM_LANES*DATA_WIDTH  registered read data, same lane packing.
REQ-012 data_valid  output  1  data_out holds an accepted read.
REQ-013 count  output  $clog2(FIFO_SIZE+1)  occupancy.
REQ-014 full / empty  output  1 each  count == FIFO_SIZE / count == 0.
REQ-015 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-016 A write is accepted when wr_en=1, wr_clr=0 and full=0, with full sampled at the start of the cycle; all lanes are written at wr_ptr.
REQ-017 A read is accepted when rd_en=1, rd_clr=0 and empty=0, with empty sampled at the start of the cycle; there is no write-to-read bypass.
REQ-018 Read latency is 1 cycle: after an accepted read, data_out = mem[rd_ptr] for all lanes and data_valid=1.
REQ-019 In any cycle without an accepted read, data_out is 0 and data_valid is 0.
REQ-020 Pointers advance only when the access is accepted and the matching _inc is 1; a pointer at FIFO_SIZE-1 wraps to 0.
REQ-021 count changes by +1 for an accepted write with wr_inc=1 and by -1 for an accepted read with rd_inc=1; simultaneous +1 and -1 leave count unchanged.
REQ-022 Accesses with _inc=0 never change count.
REQ-023 wr_en while full is dropped: memory and wr_ptr are unchanged, and overflow is set.
REQ-024 rd_en while empty returns no data and sets underflow; rd_ptr is unchanged.
REQ-025 rd_clr takes priority over rd_en: rd_ptr becomes 0, data_out becomes 0, data_valid becomes 0, and count is set to entries held since the last wr_clr (wr_ptr, or FIFO_SIZE if wr_ptr has wrapped), including a write accepted in the same cycle.
REQ-026 wr_clr takes priority over wr_en: wr_ptr becomes 0, the wrap flag clears, count becomes 0, and overflow/underflow clear; if rd_clr is also asserted, all state returns to reset values.
REQ-027 overflow and underflow stay set until wr_clr or reset.

Reset
REQ-028 While reset=1, asynchronously: pointers 0, wrap flag 0, count 0, data_out 0, data_valid 0, overflow 0, underflow 0, empty=1, full=0.
REQ-029 Memory contents are not reset.
REQ-030 Reset asserted mid-transfer aborts the transfer; the first accepted operation after release behaves as on an empty bank.

Structure
REQ-031 The shared package holds the lane-packing width function and the pointer/count width constants derived from FIFO_SIZE.
REQ-032 One sub-module, fifo_lane (single-lane DATA_WIDTH x FIFO_SIZE storage plus its output register), is instantiated NUM_LANES times.
REQ-033 Pointers, count, flags and all control logic exist exactly once, in fifo_bank.

Verification (DATA_WIDTH=8, FIFO_SIZE=6, NUM_LANES=2)
REQ-034 Write 6 entries 0x0101..0x0606 with wr_inc=1, then a 7th write 0x0707 -> full=1, count=6, overflow=1, mem unchanged; then 6 reads give 0x0101..0x0606 one cycle after each rd_en, followed by empty=1.
REQ-035 Write 4, read 4, then write 5 -> wr_ptr wraps past 5 to 3 and the 5 reads return data in order.
REQ-036 Write 0xAAAA, then rd_en with rd_inc=0 for 3 cycles -> data_out=0xAAAA and data_valid=1 each cycle, count stays 1.
REQ-037 Write 3, read 3 (empty), assert rd_clr -> count=3, next 3 reads replay the same data, and data_out=0 in idle cycles.
REQ-038 rd_en on empty -> data_valid=0, underflow=1; then wr_clr -> underflow=0; simultaneous rd_en/wr_en on full -> read accepted, write dropped, overflow=1, count=5.
REQ-039 Assert reset asynchronously between clock edges mid-burst -> all outputs are at reset values before the next edge.
